// File: rtl/pipe_hazard_ctrl_pkg.sv
// Types and constants for the pipeline hazard controller, built on defines_pipeline.vh.
`include "defines_pipeline.vh"

package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = `REG_ADDR_W;
  localparam int WAIT_W = `WAIT_CNT_W;
  localparam int PERF_W = `PERF_CNT_W;
  localparam int ST_W   = `ST_ENC_W;

  localparam logic [WAIT_W-1:0] MEM_TIMEOUT = `MEM_TIMEOUT;

  typedef enum logic [ST_W-1:0] {
    ST_RUN      = `ST_RUN_ENC,
    ST_MEM_WAIT = `ST_MEM_WAIT_ENC
  } st_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctl_t;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic             ex_load,
    input logic             ex_rf_we,
    input logic [REG_W-1:0] ex_wr,
    input logic [REG_W-1:0] rj,
    input logic             rj_used,
    input logic [REG_W-1:0] rk,
    input logic             rk_used
  );
    return ex_load & ex_rf_we & (ex_wr != '0) &
           ((rj_used & (rj == ex_wr)) | (rk_used & (rk == ex_wr)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, hold/flush controls and status out.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
;
  logic [REG_W-1:0]  id_rj;
  logic [REG_W-1:0]  id_rk;
  logic              id_rj_used;
  logic              id_rk_used;
  logic              ex_load;
  logic [REG_W-1:0]  ex_wR;
  logic              ex_rf_we;
  logic              ex_br_taken;
  logic              mem_req;
  logic              mem_ack;

  logic              pc_hold;
  logic              if_id_hold;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              id_ex_hold;
  logic              ex_mem_hold;
  logic              mem_err;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;
  logic [ST_W-1:0]   st;

  modport master (
    output id_rj, id_rk, id_rj_used, id_rk_used, ex_load, ex_wR, ex_rf_we,
           ex_br_taken, mem_req, mem_ack,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
           mem_err, stall_cnt, flush_cnt, st
  );

  modport slave (
    input  id_rj, id_rk, id_rj_used, id_rk_used, ex_load, ex_wR, ex_rf_we,
           ex_br_taken, mem_req, mem_ack,
    output pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold,
           mem_err, stall_cnt, flush_cnt, st
  );
endinterface

// File: rtl/defines_pipeline.vh
// Shared pipeline constants: FSM encodings, memory-wait timeout and counter widths.
`ifndef DEFINES_PIPELINE_VH
`define DEFINES_PIPELINE_VH

`define ST_RUN_ENC       2'd0
`define ST_MEM_WAIT_ENC  2'd1
`define ST_ENC_W         2

`define MEM_TIMEOUT      8'd255
`define WAIT_CNT_W       8
`define PERF_CNT_W       32
`define REG_ADDR_W       5

`endif

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              inc,
  output logic [PERF_W-1:0] value
);

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use bubble,
// all decoded combinationally from the current state and this cycle's pipeline status.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  pipe_hazard_ctrl_if.slave hz
);

  st_e               state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              mem_err_q, err_set;
  logic              br_flush;
  logic              load_use;
  logic              mem_stall;
  hz_ctl_t           ctl;

  assign load_use  = load_use_hit(hz.ex_load, hz.ex_rf_we, hz.ex_wR,
                                  hz.id_rj, hz.id_rj_used, hz.id_rk, hz.id_rk_used);
  assign mem_stall = hz.mem_req & ~hz.mem_ack;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    br_flush  = 1'b0;
    ctl       = '0;

    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          ctl.pc_hold     = 1'b1;
          ctl.if_id_hold  = 1'b1;
          ctl.id_ex_hold  = 1'b1;
          ctl.ex_mem_hold = 1'b1;
          wait_nxt        = '0;
          state_nxt       = ST_MEM_WAIT;
        end else if (hz.ex_br_taken) begin
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
          br_flush        = 1'b1;
        end else if (load_use) begin
          ctl.pc_hold     = 1'b1;
          ctl.if_id_hold  = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end
      end

      // Branch and load-use are not decoded here: upstream is frozen and
      // re-presents the same instructions once the access completes.
      ST_MEM_WAIT: begin
        wait_nxt = wait_cnt + WAIT_W'(1);
        if (hz.mem_ack) begin
          state_nxt = ST_RUN;
        end else begin
          ctl.pc_hold     = 1'b1;
          ctl.if_id_hold  = 1'b1;
          ctl.id_ex_hold  = 1'b1;
          ctl.ex_mem_hold = 1'b1;
          if (wait_nxt == MEM_TIMEOUT) begin
            err_set   = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (cpu_rst) begin
      ctl      = '0;
      br_flush = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  sat_counter32 u_stall_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (ctl.pc_hold),
    .value   (hz.stall_cnt)
  );

  sat_counter32 u_flush_cnt (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inc     (br_flush),
    .value   (hz.flush_cnt)
  );

  assign hz.pc_hold     = ctl.pc_hold;
  assign hz.if_id_hold  = ctl.if_id_hold;
  assign hz.id_ex_hold  = ctl.id_ex_hold;
  assign hz.ex_mem_hold = ctl.ex_mem_hold;
  assign hz.if_id_flush = ctl.if_id_flush;
  assign hz.id_ex_flush = ctl.id_ex_flush;
  assign hz.mem_err     = mem_err_q;
  assign hz.st          = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, r0, branch priority, memory wait,
// timeout and mid-wait reset, each against hand-computed expectations.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_hold;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .hz      (hz)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    hz.id_rj       = '0;
    hz.id_rk       = '0;
    hz.id_rj_used  = 1'b0;
    hz.id_rk_used  = 1'b0;
    hz.ex_load     = 1'b0;
    hz.ex_wR       = '0;
    hz.ex_rf_we    = 1'b0;
    hz.ex_br_taken = 1'b0;
    hz.mem_req     = 1'b0;
    hz.mem_ack     = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] wr, input logic [4:0] rj);
    hz.ex_load    = 1'b1;
    hz.ex_rf_we   = 1'b1;
    hz.ex_wR      = wr;
    hz.id_rj      = rj;
    hz.id_rj_used = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    cpu_rst = 1'b1;
    next_cycle();
    cpu_rst = 1'b0;
  endtask

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold} and {if_id_flush, id_ex_flush}
  function automatic logic [3:0] holds();
    return {hz.pc_hold, hz.if_id_hold, hz.id_ex_hold, hz.ex_mem_hold};
  endfunction

  function automatic logic [1:0] flushes();
    return {hz.if_id_flush, hz.id_ex_flush};
  endfunction

  initial begin
    drive_idle();
    #1;
    check("rst_st", 32'(hz.st), 32'd0);
    check("rst_holds", 32'(holds()), 32'h0);
    check("rst_flushes", 32'(flushes()), 32'h0);
    check("rst_stall_cnt", hz.stall_cnt, 32'd0);
    check("rst_flush_cnt", hz.flush_cnt, 32'd0);
    check("rst_mem_err", 32'(hz.mem_err), 32'd0);
    next_cycle();
    cpu_rst = 1'b0;

    // Load-use on rj: PC and IF_ID hold, bubble into ID_EX.
    drive_load_use(5'd5, 5'd5);
    #1;
    check("lu_holds", 32'(holds()), 32'b1100);
    check("lu_flushes", 32'(flushes()), 32'b01);
    next_cycle();
    drive_idle();
    #1;
    check("lu_stall_cnt", hz.stall_cnt, 32'd1);
    check("lu_idle_holds", 32'(holds()), 32'h0);

    // Load-use on rk; a matching rk that is not read must not stall.
    hz.ex_load = 1'b1; hz.ex_rf_we = 1'b1; hz.ex_wR = 5'd7;
    hz.id_rk = 5'd7; hz.id_rk_used = 1'b1;
    #1;
    check("lu_rk_holds", 32'(holds()), 32'b1100);
    hz.id_rk_used = 1'b0;
    #1;
    check("lu_rk_unused", 32'(holds()), 32'h0);
    hz.id_rk_used = 1'b1; hz.ex_rf_we = 1'b0;
    #1;
    check("lu_no_we", 32'(holds()), 32'h0);
    next_cycle();
    check("lu_rk_stall_cnt", hz.stall_cnt, 32'd1);

    // r0 destination never forms a hazard.
    drive_idle();
    drive_load_use(5'd0, 5'd0);
    #1;
    check("r0_holds", 32'(holds()), 32'h0);
    check("r0_flushes", 32'(flushes()), 32'h0);
    next_cycle();

    // Branch wins over load-use: flush only.
    do_reset();
    drive_load_use(5'd5, 5'd5);
    hz.ex_br_taken = 1'b1;
    #1;
    check("br_flushes", 32'(flushes()), 32'b11);
    check("br_holds", 32'(holds()), 32'h0);
    next_cycle();
    drive_idle();
    #1;
    check("br_flush_cnt", hz.flush_cnt, 32'd1);
    check("br_stall_cnt", hz.stall_cnt, 32'd0);
    check("br_one_cycle", 32'(flushes()), 32'h0);

    // Memory wait: entry cycle plus three MEM_WAIT cycles held, then ack.
    // Branch/load-use presented alongside must be ignored.
    do_reset();
    hz.mem_req = 1'b1;
    drive_load_use(5'd3, 5'd3);
    hz.ex_br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_holds", 32'(holds()), 32'hF);
      check("mw_flushes", 32'(flushes()), 32'h0);
      check("mw_st", 32'(hz.st), (i == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive_idle();
    hz.mem_ack = 1'b1;
    #1;
    check("mw_ack_holds", 32'(holds()), 32'h0);
    next_cycle();
    drive_idle();
    #1;
    check("mw_st_back", 32'(hz.st), 32'd0);
    check("mw_stall_cnt", hz.stall_cnt, 32'd4);
    check("mw_flush_cnt", hz.flush_cnt, 32'd0);

    // Timeout: ack never comes.
    do_reset();
    hz.mem_req = 1'b1;
    n_hold = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (holds() == 4'hF) n_hold++;
      next_cycle();
      if (hz.mem_err) break;
    end
    hz.mem_req = 1'b0;
    #1;
    check("to_mem_err", 32'(hz.mem_err), 32'd1);
    check("to_hold_cycles", 32'(n_hold), 32'd256);
    check("to_st", 32'(hz.st), 32'd0);
    check("to_holds_released", 32'(holds()), 32'h0);
    check("to_stall_cnt", hz.stall_cnt, 32'd256);
    next_cycle();
    next_cycle();
    check("to_mem_err_sticky", 32'(hz.mem_err), 32'd1);

    // Reset asserted mid-MEM_WAIT clears everything immediately.
    do_reset();
    hz.mem_req = 1'b1;
    next_cycle();
    next_cycle();
    check("rw_st_wait", 32'(hz.st), 32'd1);
    cpu_rst = 1'b1;
    #1;
    check("rw_holds", 32'(holds()), 32'h0);
    check("rw_flushes", 32'(flushes()), 32'h0);
    check("rw_st", 32'(hz.st), 32'd0);
    check("rw_stall_cnt", hz.stall_cnt, 32'd0);
    check("rw_flush_cnt", hz.flush_cnt, 32'd0);
    check("rw_mem_err", 32'(hz.mem_err), 32'd0);
    drive_idle();
    next_cycle();
    cpu_rst = 1'b0;
    next_cycle();
    check("rw_st_after", 32'(hz.st), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL: cpu_clk  in  1  clock; all state updates occur on its rising edge.
REQ-002 SHALL: cpu_rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: id_rj, id_rk  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL: id_rj_used, id_rk_used  in  1 each  the ID instruction reads that source.
REQ-005 SHALL: ex_load  in  1  the EX instruction is a load.
REQ-006 SHALL: ex_wR  in  5  destination register of the EX instruction.
REQ-007 SHALL: ex_rf_we  in  1  the EX instruction writes the register file.
REQ-008 SHALL: ex_br_taken  in  1  the EX branch/jump redirects the PC this cycle.
REQ-009 SHALL: mem_req, mem_ack  in  1 each  data-RAM access request from MEM and its completion.
REQ-010 SHALL: pc_hold, if_id_hold  out  1 each  freeze PC / IF_ID register.
REQ-011 SHALL: if_id_flush, id_ex_flush  out  1 each  load a bubble into that register.
REQ-012 SHALL: id_ex_hold, ex_mem_hold  out  1 each  freeze that register.
REQ-013 SHALL: mem_err  out  1  sticky memory-timeout flag.
REQ-014 SHALL: stall_cnt, flush_cnt  out  32 each  saturating performance counters.
REQ-015 SHALL: st  out  2  current FSM state encoding.

Function
REQ-016 SHALL: use FSM states RUN=0 and MEM_WAIT=1; codes 2 and 3 are illegal and return to RUN on the next edge.
REQ-017 SHALL: define load_use = ex_load & ex_rf_we & (ex_wR!=0) & ((id_rj_used & id_rj==ex_wR) | (id_rk_used & id_rk==ex_wR)).
REQ-018 SHALL: generate all hold/flush outputs combinationally from st and current-cycle inputs, with zero latency.
REQ-019 SHALL: treat a RUN-state memory stall as mem_req & ~mem_ack; in that cycle assert pc_hold, if_id_hold, id_ex_hold and ex_mem_hold, assert no flush, and enter MEM_WAIT.
REQ-020 SHALL: in MEM_WAIT, assert all four holds until the cycle in which mem_ack=1; that cycle deasserts the holds and returns to RUN.
REQ-021 SHALL: in RUN with no memory stall and ex_br_taken=1, assert if_id_flush and id_ex_flush for exactly that cycle and no holds.
REQ-022 SHALL: in RUN with no memory stall, ex_br_taken=0 and load_use=1, assert pc_hold, if_id_hold and id_ex_flush (one bubble).
REQ-023 SHALL: apply the priority memory stall > branch flush > load-use, so ex_br_taken together with load_use yields a flush only.
REQ-024 SHALL: keep an 8-bit wait counter that clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
REQ-025 SHALL: when the wait counter reaches 255 without mem_ack, set mem_err, return to RUN and release the holds; mem_err clears only on reset.
REQ-026 SHALL: increment stall_cnt in every cycle where pc_hold=1 and saturate it at 0xFFFFFFFF.
REQ-027 SHALL: increment flush_cnt once per branch-flush cycle and saturate it at 0xFFFFFFFF.
REQ-028 SHALL: ignore load_use and ex_br_taken while in MEM_WAIT; the upstream registers are frozen, so they are re-evaluated after release.

Reset
REQ-029 SHALL: on cpu_rst, drive st=RUN, wait counter=0, mem_err=0, stall_cnt=0 and flush_cnt=0.
REQ-030 SHALL: force all hold/flush outputs to 0 while cpu_rst=1, including when reset is asserted mid-MEM_WAIT.
REQ-031 SHALL: leave RUN on the first rising edge after reset deassertion only under the transition rules above.

Structure
REQ-032 SHALL: place the state encodings RUN/MEM_WAIT, the timeout constant 255 and the counter widths in defines_pipeline.vh.
REQ-033 SHALL: implement the two performance counters as instances of one sub-module, sat_counter32 (inc, value).
REQ-034 SHALL: contain no other sub-modules.

Verification
REQ-035 SHALL: load-use test: ex_load=1, ex_rf_we=1, ex_wR=5, id_rj=5, id_rj_used=1 for one cycle -> pc_hold=1, if_id_hold=1, id_ex_flush=1; stall_cnt=1.
REQ-036 SHALL: r0 test: the same stimulus with ex_wR=0 -> no hold or flush.
REQ-037 SHALL: branch+load-use test: ex_br_taken=1 together with load_use=1 -> if_id_flush=1, id_ex_flush=1, pc_hold=0; flush_cnt=1.
REQ-038 SHALL: memory-wait test: mem_req=1 with mem_ack low for 3 cycles, then high -> all four holds high for 4 cycles, st returns to 0, stall_cnt=4.
REQ-039 SHALL: timeout test: mem_req=1 with mem_ack never asserted -> mem_err=1 after 256 hold cycles, st=0, holds released.
REQ-040 SHALL: reset test: assert cpu_rst during MEM_WAIT -> outputs and counters 0 immediately; st=0.
